pwm_issue_collect: RTL and testbench

- Stream-side controller for the fixed-latency modular multiplier of the pointwise-multiplication (PWM) unit. The multiplier has no valid or stall signals, and its output must be captured by the consumer.
- Accepts operand pairs with coefficient indices over a valid/ready stream and drives them into the multiplier.
- Tracks each operation through the multiplier's fixed latency and captures each result, with its index, into an output FIFO.
- Issue is credit-limited, so a result is never dropped under output backpressure.

---
 rtl/pwm_issue_collect.sv | 144 ++++++++++++++
 tb/tb_pwm_issue_collect.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_issue_collect.sv
// Issue/collect controller for the PWM fixed-latency modular multiplier.
// Operands are issued under a credit limit; results are captured by a tag pipeline into an FWFT FIFO.
module pwm_issue_collect #(
  parameter int LATENCY    = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int IDX_W      = 8,
  parameter int PARAM_Q    = 8380417
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [22:0]                   in_a,
  input  logic [22:0]                   in_b,
  input  logic [IDX_W-1:0]              in_idx,
  output logic [22:0]                   mul_opt1,
  output logic [22:0]                   mul_opt2,
  input  logic [22:0]                   mul_result,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [22:0]                   out_data,
  output logic [IDX_W-1:0]              out_idx,
  output logic [$clog2(FIFO_DEPTH):0]   inflight,
  output logic                          busy,
  output logic                          err_overflow
);

  localparam int DW = $clog2(PARAM_Q);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = IDX_W + DW;

  logic [DW-1:0]    opt1_q, opt1_d, opt2_q, opt2_d;
  logic [LATENCY:0] tag_v_q, tag_v_d;
  logic [IDX_W-1:0] tag_idx_q [LATENCY+1];
  logic [IDX_W-1:0] tag_idx_d [LATENCY+1];
  logic [CW-1:0]    inflight_q, inflight_d;

  logic [EW-1:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    mem_cnt_q, mem_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [DW-1:0]    out_data_q, out_data_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic             err_q, err_d;

  logic          accept, capture, pop, load, push_ok, fifo_full;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credit_used;

  // The output register counts as a FIFO entry, so capacity matches the credit limit.
  assign fifo_count  = mem_cnt_q + CW'(out_valid_q);
  assign fifo_full   = (fifo_count == CW'(FIFO_DEPTH));
  assign credit_used = {1'b0, fifo_count} + {1'b0, inflight_q};
  assign in_ready    = credit_used < (CW+1)'(FIFO_DEPTH);
  assign accept      = in_valid && in_ready;
  assign capture     = tag_v_q[LATENCY];
  assign pop         = out_valid_q && out_ready;
  assign load        = (mem_cnt_q != '0) && (!out_valid_q || pop);
  assign push_ok     = capture && (!fifo_full || pop);

  always_comb begin
    opt1_d = opt1_q;
    opt2_d = opt2_q;
    if (accept) begin
      opt1_d = in_a;
      opt2_d = in_b;
    end
    tag_v_d      = {tag_v_q[LATENCY-1:0], accept};
    tag_idx_d[0] = in_idx;
    for (int unsigned i = 1; i <= LATENCY; i++) begin
      tag_idx_d[i] = tag_idx_q[i-1];
    end
    inflight_d = inflight_q + CW'(accept) - CW'(capture);
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    err_d       = err_q || (capture && fifo_full && !pop);
    mem_cnt_d   = mem_cnt_q + CW'(push_ok) - CW'(load);
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (load) begin
      {out_idx_d, out_data_d} = mem_q[rd_ptr_q];
      out_valid_d             = 1'b1;
      rd_ptr_d                = rd_ptr_q + 1'b1;
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opt1_q      <= '0;
      opt2_q      <= '0;
      tag_v_q     <= '0;
      for (int unsigned i = 0; i <= LATENCY; i++) begin
        tag_idx_q[i] <= '0;
      end
      inflight_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      opt1_q      <= opt1_d;
      opt2_q      <= opt2_d;
      tag_v_q     <= tag_v_d;
      tag_idx_q   <= tag_idx_d;
      inflight_q  <= inflight_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_cnt_q   <= mem_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= {tag_idx_q[LATENCY], mul_result};
    end
  end

  assign mul_opt1     = opt1_q;
  assign mul_opt2     = opt2_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_idx      = out_idx_q;
  assign inflight     = inflight_q;
  assign busy         = (inflight_q != '0) || (fifo_count != '0);
  assign err_overflow = err_q;

endmodule

// File: tb/tb_pwm_issue_collect.sv
// Randomized bench for pwm_issue_collect: a behavioural multiplier plus a transaction-level
// scoreboard (outstanding ops, accept timestamps) predicts every output each cycle.
module tb_pwm_issue_collect;
  localparam int L  = 8;
  localparam int D  = 16;
  localparam int IW = 8;
  localparam longint unsigned Q = 64'd8380417;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [22:0]   in_a = '0, in_b = '0;
  logic [IW-1:0] in_idx = '0;
  logic [22:0]   mul_opt1, mul_opt2, mul_result;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [22:0]   out_data;
  logic [IW-1:0] out_idx;
  logic [4:0]    inflight;
  logic          busy, err_overflow;

  pwm_issue_collect #(.LATENCY(L), .FIFO_DEPTH(D), .IDX_W(IW), .PARAM_Q(8380417)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_idx(in_idx),
    .mul_opt1(mul_opt1), .mul_opt2(mul_opt2), .mul_result(mul_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .inflight(inflight), .busy(busy), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  function automatic longint unsigned mulmod(input longint unsigned a, input longint unsigned b);
    return (a * b) % Q;
  endfunction

  // Free-running multiplier with no reset: results keep emerging regardless of the DUT state.
  logic [22:0] mpipe [L];
  always @(posedge clk) begin
    mpipe[0] <= 23'(mulmod(longint'(mul_opt1), longint'(mul_opt2)));
    for (int i = 1; i < L; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_result = mpipe[L-1];

  typedef struct {
    logic [22:0]   data;
    logic [IW-1:0] idx;
    int            acc;
  } exp_t;

  exp_t sb[$];
  int   acc_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_acc = 0;

  task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    bit exp_ov;
    while (acc_q.size() > 0 && acc_q[0] + L < cyc) void'(acc_q.pop_front());
    exp_ov = (sb.size() > 0) && (cyc >= sb[0].acc + L + 2);
    chk("out_valid", out_valid, exp_ov);
    if (exp_ov && out_valid) begin
      chk("out_data", out_data, sb[0].data);
      chk("out_idx", out_idx, sb[0].idx);
    end
    chk("in_ready", in_ready, sb.size() < D);
    chk("inflight", inflight, acc_q.size());
    chk("busy", busy, sb.size() != 0);
    chk("err_overflow", err_overflow, 0);
  endtask

  task automatic step(input bit v, input logic [22:0] a, input logic [22:0] b,
                      input logic [IW-1:0] idx, input bit ordy);
    exp_t e;
    @(negedge clk);
    check_outputs();
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_idx    = idx;
    out_ready = ordy;
    #1;
    if (out_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
    if (in_valid && in_ready) begin
      e.data = 23'(mulmod(longint'(a), longint'(b)));
      e.idx  = idx;
      e.acc  = cyc + 1;
      sb.push_back(e);
      acc_q.push_back(cyc + 1);
      n_acc++;
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && sb.size() > 0; k++) step(1'b0, '0, '0, '0, 1'b1);
    chk("drain_empty", sb.size(), 0);
    repeat (3) step(1'b0, '0, '0, '0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_mul_opt1", mul_opt1, 0);
    chk("rst_mul_opt2", mul_opt2, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_overflow, 0);
    chk("rst_in_ready", in_ready, 1);
    sb.delete();
    acc_q.delete();
    @(posedge clk);
    cyc++;
    #2 rst_n = 1'b1;
  endtask

  function automatic logic [22:0] rnd_op();
    return 23'($urandom_range(8380416, 0));
  endfunction

  initial begin
    do_reset();

    // single op: (Q-1)^2 mod Q = 1
    step(1'b1, 23'd8380416, 23'd8380416, 8'd5, 1'b1);
    drain();

    for (int i = 0; i < 256; i++) begin
      logic [31:0] iv;
      iv = i;
      step(1'b1, iv[22:0], 23'd2, iv[7:0], 1'b1);
    end
    drain();

    n_acc = 0;
    repeat (30) step(1'b1, rnd_op(), rnd_op(), 8'($urandom), 1'b0);
    chk("bp_accepts", n_acc, D);
    drain();

    repeat (20) step(1'b1, rnd_op(), rnd_op(), 8'($urandom), 1'b0);
    for (int k = 0; k < 80; k++) step(1'b1, rnd_op(), rnd_op(), 8'($urandom), k[0]);
    drain();

    for (int k = 0; k < 5; k++) step(1'b1, rnd_op(), rnd_op(), 8'(k), 1'b1);
    repeat (2) step(1'b0, '0, '0, '0, 1'b1);
    do_reset();
    repeat (20) step(1'b0, '0, '0, '0, 1'b1);

    n_acc = 0;
    for (int k = 0; k < 8000 && n_acc < 1000; k++)
      step(1'($urandom), rnd_op(), rnd_op(), 8'($urandom), 1'($urandom));
    chk("random_ops", n_acc, 1000);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

endmodule
